// File: rtl/ofdm_symbol_scheduler.sv
// rtl/ofdm_symbol_scheduler.sv - drops preamble and cyclic prefixes, forwards FFT-sized symbols with strobes
module ofdm_symbol_scheduler #(
  parameter int PREAMBLE_LEN = 320,
  parameter int CP_LEN       = 16,
  parameter int FFT_LEN      = 64,
  parameter int DRAIN_CYCLES = 91,
  parameter int DW           = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic [7:0]    n_sym,
  input  logic          valid_in,
  input  logic [DW-1:0] data_in_re,
  input  logic [DW-1:0] data_in_im,
  output logic [DW-1:0] data_out_re,
  output logic [DW-1:0] data_out_im,
  output logic          valid_out,
  output logic          sym_start,
  output logic          sym_end,
  output logic          last_symbol,
  output logic          frame_done,
  output logic          busy
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_CP, S_DATA, S_DRAIN, S_DONE} state_e;

  localparam logic [8:0] PRE_LAST   = 9'(PREAMBLE_LEN - 1);
  localparam logic [6:0] CP_LAST    = 7'(CP_LEN - 1);
  localparam logic [6:0] FFT_LAST   = 7'(FFT_LEN - 1);
  localparam logic [6:0] DRAIN_LAST = 7'(DRAIN_CYCLES - 1);

  state_e        state_q;
  logic [8:0]    pre_cnt_q;
  logic [6:0]    cnt_q;
  logic [6:0]    drain_cnt_q;
  logic [7:0]    sym_left_q;
  logic [DW-1:0] data_re_q, data_im_q;
  logic          valid_q, sym_start_q, sym_end_q, last_symbol_q, frame_done_q, busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pre_cnt_q     <= '0;
      cnt_q         <= '0;
      drain_cnt_q   <= '0;
      sym_left_q    <= '0;
      data_re_q     <= '0;
      data_im_q     <= '0;
      valid_q       <= 1'b0;
      sym_start_q   <= 1'b0;
      sym_end_q     <= 1'b0;
      last_symbol_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      valid_q      <= 1'b0;
      sym_start_q  <= 1'b0;
      sym_end_q    <= 1'b0;
      frame_done_q <= 1'b0;
      // A new frame_start always wins, aborting whatever frame is in flight.
      if (frame_start) begin
        state_q       <= S_PRE;
        sym_left_q    <= n_sym;
        pre_cnt_q     <= '0;
        cnt_q         <= '0;
        drain_cnt_q   <= '0;
        last_symbol_q <= 1'b0;
        busy_q        <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: busy_q <= 1'b0;
          S_PRE: if (valid_in) begin
            if (pre_cnt_q == PRE_LAST) begin
              pre_cnt_q <= '0;
              cnt_q     <= '0;
              if (sym_left_q != 8'd0) begin
                state_q <= S_CP;
              end else begin
                state_q      <= S_DONE;
                frame_done_q <= 1'b1;
              end
            end else begin
              pre_cnt_q <= pre_cnt_q + 9'd1;
            end
          end
          S_CP: if (valid_in) begin
            if (cnt_q == CP_LAST) begin
              cnt_q   <= '0;
              state_q <= S_DATA;
            end else begin
              cnt_q <= cnt_q + 7'd1;
            end
          end
          S_DATA: if (valid_in) begin
            valid_q     <= 1'b1;
            data_re_q   <= data_in_re;
            data_im_q   <= data_in_im;
            sym_start_q <= (cnt_q == 7'd0);
            if (cnt_q == 7'd0 && sym_left_q == 8'd1) last_symbol_q <= 1'b1;
            if (cnt_q == FFT_LAST) begin
              sym_end_q  <= 1'b1;
              sym_left_q <= sym_left_q - 8'd1;
              cnt_q      <= '0;
              if (sym_left_q == 8'd1) begin
                state_q     <= S_DRAIN;
                drain_cnt_q <= '0;
              end else begin
                state_q <= S_CP;
              end
            end else begin
              cnt_q <= cnt_q + 7'd1;
            end
          end
          S_DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
              drain_cnt_q   <= '0;
              last_symbol_q <= 1'b0;
              state_q       <= S_DONE;
              frame_done_q  <= 1'b1;
            end else begin
              drain_cnt_q <= drain_cnt_q + 7'd1;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign data_out_re = data_re_q;
  assign data_out_im = data_im_q;
  assign valid_out   = valid_q;
  assign sym_start   = sym_start_q;
  assign sym_end     = sym_end_q;
  assign last_symbol = last_symbol_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// tb/tb_ofdm_symbol_scheduler.sv - randomized frame bench against a sample-index reference model
module tb_ofdm_symbol_scheduler;
  localparam int DW = 12;
  localparam int PRE = 320;
  localparam int CPL = 16;
  localparam int FFT = 64;
  localparam int SYM = CPL + FFT;
  localparam int DRAIN = 91;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0;
  logic [7:0]    n_sym = '0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in_re = '0;
  logic [DW-1:0] data_in_im = '0;
  logic [DW-1:0] data_out_re, data_out_im;
  logic          valid_out, sym_start, sym_end, last_symbol, frame_done, busy;

  ofdm_symbol_scheduler dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .n_sym(n_sym),
    .valid_in(valid_in), .data_in_re(data_in_re), .data_in_im(data_in_im),
    .data_out_re(data_out_re), .data_out_im(data_out_im), .valid_out(valid_out),
    .sym_start(sym_start), .sym_end(sym_end), .last_symbol(last_symbol),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total = 0;

  // Accepted input samples (edge that captured them) and forwarded outputs (edge that produced them).
  int            in_cyc[$];
  logic [DW-1:0] in_re[$], in_im[$];
  int            out_cyc[$];
  logic [DW-1:0] out_re[$], out_im[$];
  bit            out_ss[$], out_se[$];
  int            fd_cyc[$];
  int            ls_rise, ls_fall;

  function automatic int fwd_mismatches(input int n);
    int bad = 0;
    if (out_cyc.size() != n * FFT || in_cyc.size() < PRE + SYM * n) return 99999;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < FFT; j++) begin
        int o = k * FFT + j;
        int idx = PRE + SYM * k + CPL + j;
        if (out_re[o] !== in_re[idx] || out_im[o] !== in_im[idx] || out_cyc[o] != in_cyc[idx] ||
            out_ss[o] != (j == 0) || out_se[o] != (j == FFT - 1)) bad++;
      end
    end
    return bad;
  endfunction

  function automatic int exp_done(input int n);
    if (in_cyc.size() < PRE + SYM * n) return -2;
    if (n == 0) return in_cyc[PRE - 1];
    return in_cyc[PRE + SYM * n - 1] + DRAIN;
  endfunction

  function automatic int exp_rise(input int n);
    if (n == 0) return -1;
    if (in_cyc.size() < PRE + SYM * n) return -2;
    return in_cyc[PRE + SYM * (n - 1) + CPL];
  endfunction

  function automatic int exp_fall(input int n);
    if (n == 0) return -1;
    if (in_cyc.size() < PRE + SYM * n) return -2;
    return in_cyc[PRE + SYM * n - 1] + DRAIN;
  endfunction

  function automatic int first_fd();
    return (fd_cyc.size() > 0) ? fd_cyc[0] : -1;
  endfunction

  // mode: 0 continuous valid, 1 alternating, 2 random. abort_at>0 restarts with n2 after that many samples.
  task automatic drive_frame(input int n, input int mode, input bit ramp, input int abort_at, input int n2);
    int extra = -1;
    bit aborted = 1'b0;
    bit ls_prev;
    int idx;
    int budget = (PRE + SYM * (n + n2)) * 4 + 400;
    in_cyc.delete(); in_re.delete(); in_im.delete();
    out_cyc.delete(); out_re.delete(); out_im.delete(); out_ss.delete(); out_se.delete();
    fd_cyc.delete();
    ls_rise = -1;
    ls_fall = -1;
    frame_start = 1'b1;
    n_sym = 8'(n);
    valid_in = 1'($urandom);
    data_in_re = DW'($urandom);
    data_in_im = DW'($urandom);
    @(posedge clk); #1;
    ls_prev = last_symbol;
    for (int c = 0; c < budget; c++) begin
      if (abort_at > 0 && !aborted && in_cyc.size() == abort_at) begin
        frame_start = 1'b1;
        n_sym = 8'(n2);
        valid_in = 1'b1;
        aborted = 1'b1;
        in_cyc.delete(); in_re.delete(); in_im.delete();
        out_cyc.delete(); out_re.delete(); out_im.delete(); out_ss.delete(); out_se.delete();
      end else begin
        frame_start = 1'b0;
        case (mode)
          0: valid_in = 1'b1;
          1: valid_in = (c % 2 == 0);
          default: valid_in = ($urandom_range(0, 2) != 0);
        endcase
        idx = in_cyc.size();
        data_in_re = (ramp && valid_in) ? DW'(idx) : DW'($urandom);
        data_in_im = (ramp && valid_in) ? ~DW'(idx) : DW'($urandom);
        if (valid_in) begin
          in_cyc.push_back(cyc + 1);
          in_re.push_back(data_in_re);
          in_im.push_back(data_in_im);
        end
      end
      @(posedge clk); #1;
      if (valid_out) begin
        out_cyc.push_back(cyc);
        out_re.push_back(data_out_re);
        out_im.push_back(data_out_im);
        out_ss.push_back(sym_start);
        out_se.push_back(sym_end);
      end
      if (frame_done) fd_cyc.push_back(cyc);
      if (last_symbol && !ls_prev && ls_rise < 0) ls_rise = cyc;
      if (!last_symbol && ls_prev && ls_fall < 0) ls_fall = cyc;
      ls_prev = last_symbol;
      if (frame_done && extra < 0) extra = 4;
      if (extra == 0) break;
      if (extra > 0) extra--;
    end
    frame_start = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({valid_out, sym_start, sym_end, last_symbol, frame_done, busy, data_out_re, data_out_im} !== '0)
      $display("FAIL reset_outputs: got %h required 0",
               {valid_out, sym_start, sym_end, last_symbol, frame_done, busy, data_out_re, data_out_im});
    else passed++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_continuous();
    drive_frame(2, 0, 1'b1, 0, 0);
    total++;
    if (out_cyc.size() != 2 * FFT) $display("FAIL cont_count: got %0d required %0d", out_cyc.size(), 2 * FFT);
    else passed++;
    total++;
    if (fwd_mismatches(2) != 0) $display("FAIL cont_samples: mismatches %0d required 0", fwd_mismatches(2));
    else passed++;
    total++;
    if (ls_rise != exp_rise(2)) $display("FAIL cont_ls_rise: got %0d required %0d", ls_rise, exp_rise(2));
    else passed++;
    total++;
    if (ls_fall != exp_fall(2)) $display("FAIL cont_ls_fall: got %0d required %0d", ls_fall, exp_fall(2));
    else passed++;
    total++;
    if (fd_cyc.size() != 1 || first_fd() != exp_done(2))
      $display("FAIL cont_done: got %0d pulses first %0d required 1 at %0d", fd_cyc.size(), first_fd(), exp_done(2));
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL cont_idle_busy: got %b required 0", busy);
    else passed++;
  endtask

  task automatic test_toggle();
    drive_frame(2, 1, 1'b0, 0, 0);
    total++;
    if (fwd_mismatches(2) != 0) $display("FAIL toggle_samples: mismatches %0d required 0", fwd_mismatches(2));
    else passed++;
    total++;
    if (ls_fall != exp_fall(2)) $display("FAIL toggle_drain: got %0d required %0d", ls_fall, exp_fall(2));
    else passed++;
    total++;
    if (fd_cyc.size() != 1 || first_fd() != exp_done(2))
      $display("FAIL toggle_done: got %0d pulses first %0d required 1 at %0d", fd_cyc.size(), first_fd(), exp_done(2));
    else passed++;
  endtask

  task automatic test_zero_symbols();
    drive_frame(0, 2, 1'b0, 0, 0);
    total++;
    if (out_cyc.size() != 0) $display("FAIL zero_count: got %0d required 0", out_cyc.size());
    else passed++;
    total++;
    if (ls_rise != -1) $display("FAIL zero_last_symbol: rise at %0d required none", ls_rise);
    else passed++;
    total++;
    if (fd_cyc.size() != 1 || first_fd() != exp_done(0))
      $display("FAIL zero_done: got %0d pulses first %0d required 1 at %0d", fd_cyc.size(), first_fd(), exp_done(0));
    else passed++;
  endtask

  task automatic test_abort();
    drive_frame(3, 0, 1'b0, PRE + SYM + 5, 1);
    total++;
    if (fwd_mismatches(1) != 0) $display("FAIL abort_samples: mismatches %0d required 0 (count %0d)", fwd_mismatches(1), out_cyc.size());
    else passed++;
    total++;
    if (fd_cyc.size() != 1 || first_fd() != exp_done(1))
      $display("FAIL abort_done: got %0d pulses first %0d required 1 at %0d", fd_cyc.size(), first_fd(), exp_done(1));
    else passed++;
    total++;
    if (ls_rise != exp_rise(1)) $display("FAIL abort_ls_rise: got %0d required %0d", ls_rise, exp_rise(1));
    else passed++;
  endtask

  task automatic test_random_frames();
    for (int it = 0; it < 3; it++) begin
      int n = $urandom_range(1, 3);
      drive_frame(n, 2, 1'b0, 0, 0);
      total++;
      if (fwd_mismatches(n) != 0) $display("FAIL rand%0d_samples: mismatches %0d required 0", it, fwd_mismatches(n));
      else passed++;
      total++;
      if (ls_rise != exp_rise(n) || ls_fall != exp_fall(n))
        $display("FAIL rand%0d_last_symbol: got %0d..%0d required %0d..%0d", it, ls_rise, ls_fall, exp_rise(n), exp_fall(n));
      else passed++;
      total++;
      if (fd_cyc.size() != 1 || first_fd() != exp_done(n))
        $display("FAIL rand%0d_done: got %0d pulses first %0d required 1 at %0d", it, fd_cyc.size(), first_fd(), exp_done(n));
      else passed++;
    end
  endtask

  task automatic test_max_symbols();
    drive_frame(255, 0, 1'b0, 0, 0);
    total++;
    if (out_cyc.size() != 255 * FFT) $display("FAIL max_count: got %0d required %0d", out_cyc.size(), 255 * FFT);
    else passed++;
    total++;
    if (fd_cyc.size() != 1 || first_fd() != exp_done(255))
      $display("FAIL max_done: got %0d pulses first %0d required 1 at %0d", fd_cyc.size(), first_fd(), exp_done(255));
    else passed++;
  endtask

  task automatic test_back_to_back();
    int waited = 0;
    int early = 0;
    frame_start = 1'b1;
    n_sym = 8'd0;
    valid_in = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    while (!frame_done && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    total++;
    if (waited != PRE) $display("FAIL b2b_first_done: got %0d cycles required %0d", waited, PRE);
    else passed++;
    frame_start = 1'b1;
    n_sym = 8'd1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    total++;
    if (frame_done !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_restart: got done=%b busy=%b required 0 1", frame_done, busy);
    else passed++;
    for (int i = 0; i < PRE + CPL; i++) begin
      @(posedge clk); #1;
      if (valid_out) early++;
    end
    total++;
    if (early != 0) $display("FAIL b2b_early_output: got %0d required 0", early);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({valid_out, sym_start, last_symbol} !== 3'b111)
      $display("FAIL b2b_first_sample: got %b required 111", {valid_out, sym_start, last_symbol});
    else passed++;
    waited = 0;
    while (!frame_done && waited < 400) begin
      @(posedge clk); #1;
      waited++;
    end
    total++;
    if (waited != FFT - 1 + DRAIN) $display("FAIL b2b_second_done: got %0d cycles required %0d", waited, FFT - 1 + DRAIN);
    else passed++;
    valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_frame();
    int waited = 0;
    int leaked = 0;
    frame_start = 1'b1;
    n_sym = 8'd1;
    valid_in = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    while (!valid_out && waited < 800) begin
      data_in_re = DW'($urandom_range(1, 4095));
      data_in_im = DW'($urandom_range(1, 4095));
      @(posedge clk); #1;
      waited++;
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (valid_out !== 1'b1 || last_symbol !== 1'b1)
      $display("FAIL rst_mid_pre: got valid=%b last=%b required 1 1", valid_out, last_symbol);
    else passed++;
    #2 reset = 1'b0;
    #1;
    total++;
    if ({valid_out, sym_start, sym_end, last_symbol, frame_done, busy, data_out_re, data_out_im} !== '0)
      $display("FAIL rst_mid_outputs: got %h required 0",
               {valid_out, sym_start, sym_end, last_symbol, frame_done, busy, data_out_re, data_out_im});
    else passed++;
    reset = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (valid_out || busy || frame_done) leaked++;
    end
    total++;
    if (leaked != 0) $display("FAIL rst_mid_after: got %0d active cycles required 0", leaked);
    else passed++;
    valid_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_toggle();
    test_zero_symbols();
    test_abort();
    test_random_frames();
    test_back_to_back();
    test_max_symbols();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ofdm_symbol_scheduler.md
Name: ofdm_symbol_scheduler

Overview:
Receive-side frame sequencer between the sample RAM readout and the 64-point FFT in the WiFi PHY. On frame_start it discards the preamble, strips the 16-sample cyclic prefix from each OFDM symbol and forwards the 64 useful samples with symbol-boundary strobes. It flags the final symbol and holds that flag through a fixed FFT drain window before declaring the frame done. It replaces free-running preamble skipping with an explicit, per-frame, symbol-counted schedule.

Parameters:
PREAMBLE_LEN, 320, valid samples discarded after frame_start
CP_LEN, 16, cyclic-prefix samples discarded per symbol
FFT_LEN, 64, useful samples forwarded per symbol
DRAIN_CYCLES, 91, clock cycles last_symbol stays high after the final sym_end
DW, 12, sample width per I/Q component

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
frame_start  in  1  one-cycle pulse; latches n_sym and starts a frame
n_sym  in  8  number of data symbols in the frame (0..255)
valid_in  in  1  sample qualifier
data_in_re  in  DW  in-phase sample
data_in_im  in  DW  quadrature sample
data_out_re  out  DW  forwarded in-phase sample
data_out_im  out  DW  forwarded quadrature sample
valid_out  out  1  forwarded-sample qualifier
sym_start  out  1  high with the first forwarded sample of each symbol
sym_end  out  1  high with the 64th forwarded sample of each symbol
last_symbol  out  1  final symbol in progress or draining
frame_done  out  1  one-cycle completion pulse
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset==0): state=IDLE. All counters cleared. valid_out, sym_start, sym_end, last_symbol, frame_done and busy are 0. data_out_re and data_out_im are 0.
- All outputs are registered, with one-cycle latency from the qualifying valid_in sample.
- Sample counters advance only on cycles with valid_in=1. Cycles with valid_in=0 stall them; state and counts hold.
- States:
  - IDLE: on frame_start, latch n_sym into sym_left and go to PRE.
  - PRE: count PREAMBLE_LEN valid samples; nothing is forwarded. After the last one, go to CP if sym_left>0, else go to DONE.
  - CP: count CP_LEN valid samples; nothing is forwarded. Then go to DATA.
  - DATA: forward each valid sample with valid_out=1.
    - First sample: sym_start=1. It is also the first sample of the final symbol when sym_left==1; last_symbol goes 1 with it.
    - 64th sample: sym_end=1 and sym_left decrements. If the new sym_left>0, go to CP; else go to DRAIN.
  - DRAIN: count DRAIN_CYCLES clock cycles, regardless of valid_in. Input is ignored and valid_out=0. last_symbol stays 1. Then last_symbol goes 0 and the state goes to DONE.
  - DONE: frame_done=1 for exactly one cycle, then go to IDLE.
- valid_out, sym_start and sym_end are 0 whenever the registered sample is not a forwarded DATA sample.
- data_out holds its last value when valid_out=0.
- frame_start while busy: abort the current frame, clear counters and last_symbol, latch the new n_sym, enter PRE. No frame_done is issued for the aborted frame.
- frame_start coincident with the DONE cycle: frame_done still pulses, and the new frame enters PRE.
- n_sym=0: PRE then DONE. No valid_out and no last_symbol.
- n_sym=255: sym_left is 8 bits wide, so there is no wrap.
- Preamble counter is 9 bits, CP/DATA counter is 7 bits, drain counter is 7 bits. Counters reload to 0 on every state entry.
- Reset asserted mid-frame: immediate return to the reset state. Partial symbols are not flushed.

Test Plan:
- Reset, then frame_start with n_sym=2 and continuous valid_in: first valid_out exactly 1+320+16 valid samples after the start; 128 forwarded samples total. sym_start at forwarded samples 1 and 65, sym_end at 64 and 128. last_symbol rises with sample 65, falls 91 cycles after the second sym_end, then one frame_done pulse.
- Same frame with valid_in toggling 1/0: identical forwarded sample sequence and strobes, no dropped or duplicated samples. DRAIN length is still 91 cycles.
- n_sym=0: no valid_out and no last_symbol; frame_done 1 cycle after the 320th valid sample is consumed.
- frame_start with n_sym=3, then a second frame_start during the CP of symbol 2 with n_sym=1: exactly 64 forwarded after the next preamble, a single frame_done, last_symbol active only for the new frame.
- reset pulled low during DATA of symbol 1: all outputs 0 in the same cycle. After release, nothing is forwarded until the next frame_start.
- Ramp data (re=index, im=~index): forwarded samples equal input indices 336..399 for symbol 1 and 416..479 for symbol 2 (0-based from frame start).
